// File: rtl/inert_slv_pkg.sv
// inert_slv_pkg
//   Shared definitions for the inertial-sensor SPI responder:
//   register addresses, CTRL/STATUS bit positions and the
//   controller state type.
package inert_slv_pkg;

  // 7-bit register addresses (frame bits 14:8)
  localparam logic [6:0] ADDR_CTRL     = 7'h0D;
  localparam logic [6:0] ADDR_WHO_AM_I = 7'h0F;
  localparam logic [6:0] ADDR_STATUS   = 7'h1E;
  localparam logic [6:0] ADDR_PTCH_L   = 7'h22;
  localparam logic [6:0] ADDR_PTCH_H   = 7'h23;
  localparam logic [6:0] ADDR_AZ_L     = 7'h2C;
  localparam logic [6:0] ADDR_AZ_H     = 7'h2D;
  localparam logic [6:0] ADDR_ERR_CNT  = 7'h7F;

  // CTRL / STATUS bit indices
  localparam int CTRL_INT_EN = 1;
  localparam int STATUS_NEW  = 0;
  localparam int STATUS_OVR  = 1;
  localparam int STATUS_ERR  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } slv_state_t;

endpackage

// File: rtl/inert_sensor_slv_shft.sv
// spi_slv_shft
//   SPI mode-0 serial front end: synchronizes SS_n/SCLK/MOSI, detects
//   SCLK edges, counts rises, shifts in the 16-bit frame and shifts the
//   read byte out on MISO.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ss_n, sclk, mosi  raw serial inputs from the master
//   rd_byte      register byte selected by the top from rx_data[6:0]
//   miso         serial data to master
//   addr_vld     pulse one clk after the 8th rise (rx_data[7:0] = R/W+addr)
//   frm_done     SS_n rise with exactly 16 rises in the frame
//   frm_err      SS_n rise with any other rise count
//   ss_fall      synchronized SS_n fall pulse
//   rx_data      received frame shift register
module spi_slv_shft #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ss_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic [7:0]  rd_byte,
  output logic        miso,
  output logic        addr_vld,
  output logic        frm_done,
  output logic        frm_err,
  output logic        ss_fall,
  output logic [15:0] rx_data
);

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic ss_s, sclk_s, mosi_s;
  logic ss_d, sclk_d;
  logic sclk_rise, sclk_fall, ss_rise;
  logic [4:0] bit_cnt;
  logic [7:0] tx;

  // Select idles high so a reset never looks like a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d & ~ss_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~ss_s;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;

  assign frm_done = ss_rise & (bit_cnt == 5'd16);
  assign frm_err  = ss_rise & (bit_cnt != 5'd16);
  assign miso     = tx[7] & ~ss_s;

  // The fall right after rise 8 must not shift: bit 7 is loaded for rise 9,
  // so shifting starts at the fall following rise 9. The counter saturates
  // so over-long frames never wrap back to a valid count of 16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d   <= 1'b0;
      ss_d     <= 1'b1;
      bit_cnt  <= 5'd0;
      rx_data  <= 16'h0000;
      addr_vld <= 1'b0;
      tx       <= 8'h00;
    end else begin
      sclk_d   <= sclk_s;
      ss_d     <= ss_s;
      addr_vld <= sclk_rise & (bit_cnt == 5'd7);
      if (ss_fall)
        bit_cnt <= 5'd0;
      else if (sclk_rise && bit_cnt != 5'd31)
        bit_cnt <= bit_cnt + 5'd1;
      if (sclk_rise)
        rx_data <= {rx_data[14:0], mosi_s};
      if (ss_s)
        tx <= 8'h00;
      else if (addr_vld)
        tx <= rx_data[7] ? rd_byte : 8'h00;
      else if (sclk_fall && bit_cnt >= 5'd9)
        tx <= {tx[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/inert_sensor_slv.sv
// inert_sensor_slv
//   SPI responder modelling the segway inertial sensor: register map,
//   sample capture, overrun tracking and data-ready interrupt.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   SS_n, SCLK, MOSI    SPI inputs from the controller's master
//   MISO                SPI read data
//   INT                 registered data-ready interrupt (STATUS.new & INT_EN)
//   ptch_data, az_data  sample sources, latched on data_rdy
//   data_rdy            one-clk capture pulse
// Build option INERT_SLV_FRM_ERR_EN adds ERR_CNT (0x7F) and STATUS bit7.
module inert_sensor_slv
  import inert_slv_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL     = 8'h6A,
  parameter int         SCLK_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] ptch_data,
  input  logic [15:0] az_data,
  input  logic        data_rdy
);

  slv_state_t state, state_nxt;
  logic [15:0] rx_data;
  logic [7:0]  rd_byte, ctrl, status_byte, err_cnt;
  logic [15:0] ptch, az;
  logic addr_vld, frm_done, frm_err, ss_fall;
  logic new_flag, ovr_flag, err_flag, int_q;
  logic commit_ok, err_ok, rd_commit, wr_ctrl, rd_clr;

  spi_slv_shft #(.SYNC_STAGES(SCLK_SYNC_STAGES)) u_shft (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_n     (SS_n),
    .sclk     (SCLK),
    .mosi     (MOSI),
    .rd_byte  (rd_byte),
    .miso     (MISO),
    .addr_vld (addr_vld),
    .frm_done (frm_done),
    .frm_err  (frm_err),
    .ss_fall  (ss_fall),
    .rx_data  (rx_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A new select fall seen while in COMMIT goes straight back to SHIFT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = SHIFT;
      SHIFT:   if (frm_done || frm_err) state_nxt = COMMIT;
      COMMIT:  state_nxt = ss_fall ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame-end actions use the full frame: R/W in bit15, address in 14:8
  assign commit_ok = (state == SHIFT) & frm_done;
  assign err_ok    = (state == SHIFT) & frm_err;
  assign rd_commit = commit_ok & rx_data[15];
  assign wr_ctrl   = commit_ok & ~rx_data[15] & (rx_data[14:8] == ADDR_CTRL);
  assign rd_clr    = rd_commit & (rx_data[14:8] == ADDR_PTCH_H);

  always_comb begin
    status_byte = 8'h00;
    status_byte[STATUS_NEW] = new_flag;
    status_byte[STATUS_OVR] = ovr_flag;
    status_byte[STATUS_ERR] = err_flag;
  end

  // Read mux is addressed while only 8 bits are in: address sits in rx[6:0]
  always_comb begin
    rd_byte = 8'h00;
    case (rx_data[6:0])
      ADDR_CTRL:     rd_byte = ctrl;
      ADDR_WHO_AM_I: rd_byte = WHO_AM_I_VAL;
      ADDR_STATUS:   rd_byte = status_byte;
      ADDR_PTCH_L:   rd_byte = ptch[7:0];
      ADDR_PTCH_H:   rd_byte = ptch[15:8];
      ADDR_AZ_L:     rd_byte = az[7:0];
      ADDR_AZ_H:     rd_byte = az[15:8];
      ADDR_ERR_CNT:  rd_byte = err_cnt;
      default:       rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl <= 8'h00;
    else if (wr_ctrl) ctrl <= rx_data[7:0];
  end

  // Capture beats a simultaneous clear-on-read; overrun only when a
  // previous sample was still unread (overrun implies new is set).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch     <= 16'h0000;
      az       <= 16'h0000;
      new_flag <= 1'b0;
      ovr_flag <= 1'b0;
    end else if (data_rdy) begin
      ptch     <= ptch_data;
      az       <= az_data;
      new_flag <= 1'b1;
      ovr_flag <= ovr_flag | new_flag;
    end else if (rd_clr) begin
      new_flag <= 1'b0;
      ovr_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) int_q <= 1'b0;
    else        int_q <= new_flag & ctrl[CTRL_INT_EN];
  end

  assign INT = int_q;

`ifdef INERT_SLV_FRM_ERR_EN
  // Saturating discard counter and sticky flag, flag cleared by reading ERR_CNT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= 8'h00;
      err_flag <= 1'b0;
    end else if (err_ok) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
      err_flag <= 1'b1;
    end else if (rd_commit && rx_data[14:8] == ADDR_ERR_CNT) begin
      err_flag <= 1'b0;
    end
  end
`else
  assign err_cnt  = 8'h00;
  assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_inert_sensor_slv.sv
// tb_inert_sensor_slv
//   Self-checking bench for inert_sensor_slv: directed scenarios followed by
//   randomized frames, compared against a register-level reference model.
//   Honours INERT_SLV_FRM_ERR_EN the same way the design does.
module tb_inert_sensor_slv;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic SS_n = 1'b1, SCLK = 1'b0, MOSI = 1'b0, data_rdy = 1'b0;
  logic [15:0] ptch_data = 16'h0000, az_data = 16'h0000;
  logic MISO, INT;

  int passCount = 0;
  int checkCount = 0;

  // Reference model state
  logic [7:0]  mCtrl;
  logic [15:0] mPtch, mAz;
  logic        mNew, mOvr, mErrFlag;
  int          mErrCnt;

  always #5 clk = ~clk;

  inert_sensor_slv #(.WHO_AM_I_VAL(8'h6A), .SCLK_SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .INT       (INT),
    .ptch_data (ptch_data),
    .az_data   (az_data),
    .data_rdy  (data_rdy)
  );

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  task automatic modelReset();
    mCtrl = 8'h00; mPtch = 16'h0000; mAz = 16'h0000;
    mNew = 1'b0; mOvr = 1'b0; mErrFlag = 1'b0; mErrCnt = 0;
  endtask

  function automatic logic [7:0] modelRead(input logic [6:0] a);
    case (a)
      7'h0D: return mCtrl;
      7'h0F: return 8'h6A;
      7'h1E: return {mErrFlag, 5'b00000, mOvr, mNew};
      7'h22: return mPtch[7:0];
      7'h23: return mPtch[15:8];
      7'h2C: return mAz[7:0];
      7'h2D: return mAz[15:8];
`ifdef INERT_SLV_FRM_ERR_EN
      7'h7F: return mErrCnt[7:0];
`endif
      default: return 8'h00;
    endcase
  endfunction

  // Register-level effect of a completed (or discarded) frame
  task automatic modelFrame(input logic [15:0] w, input int nbits);
    if (nbits == 16) begin
      if (w[15]) begin
        if (w[14:8] == 7'h23) begin mNew = 1'b0; mOvr = 1'b0; end
        if (w[14:8] == 7'h7F) mErrFlag = 1'b0;
      end else if (w[14:8] == 7'h0D) begin
        mCtrl = w[7:0];
      end
    end else begin
`ifdef INERT_SLV_FRM_ERR_EN
      if (mErrCnt < 255) mErrCnt++;
      mErrFlag = 1'b1;
`endif
    end
  endtask

  // Master side of one frame: SCLK period 10 clk, MISO sampled before each
  // rise 9..16. With coin set, data_rdy lands on the clk that acts on SS_n rise.
  task automatic applyStimulus(input logic [15:0] w, input int nbits, input bit coin,
                               output logic [7:0] rb);
    logic [15:0] sh;
    sh = w;
    rb = 8'h00;
    SS_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = sh[15];
      sh = {sh[14:0], 1'b0};
      repeat (5) @(negedge clk);
      if (i >= 8 && i < 16) rb = {rb[6:0], MISO};
      SCLK = 1'b1;
      repeat (5) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    SS_n = 1'b1;
    if (coin) begin
      repeat (SYNC) @(negedge clk);
      data_rdy = 1'b1;
      @(negedge clk);
      data_rdy = 1'b0;
      for (int k = 0; k < 6; k++) begin
        checkOutput("coin_int_held", {15'b0, INT}, 16'h0001);
        @(negedge clk);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic doFrame(input string tag, input logic [15:0] w, input int nbits);
    logic [7:0] exp, rb;
    exp = modelRead(w[14:8]);
    applyStimulus(w, nbits, 1'b0, rb);
    if (w[15] && nbits == 16) checkOutput(tag, {8'h00, rb}, {8'h00, exp});
    modelFrame(w, nbits);
  endtask

  task automatic pulseRdy(input logic [15:0] p, input logic [15:0] a);
    ptch_data = p; az_data = a;
    data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
    mPtch = p; mAz = a;
    mOvr = mOvr | mNew;
    mNew = 1'b1;
  endtask

  task automatic checkInt(input string tag);
    checkOutput(tag, {15'b0, INT}, {15'b0, mNew & mCtrl[1]});
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] rb, exp;
    logic [15:0] sh;
    logic [6:0] addrs [9];
    logic prevNew;
    int op, nb;
    addrs = '{7'h0D, 7'h0F, 7'h1E, 7'h22, 7'h23, 7'h2C, 7'h2D, 7'h7F, 7'h40};

    #1 rst_n = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_miso", {15'b0, MISO}, 16'h0000);
    checkOutput("reset_int", {15'b0, INT}, 16'h0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    doFrame("whoami", 16'h8F00, 16);
    checkInt("whoami_int");

    doFrame("wr_ctrl", 16'h0D02, 16);
    pulseRdy(16'hF3A5, 16'h1234);
    @(negedge clk);
    checkOutput("int_rise", {15'b0, INT}, 16'h0001);
    doFrame("ptch_l", 16'hA200, 16);
    doFrame("ptch_h", 16'hA300, 16);
    checkInt("int_cleared");

    pulseRdy(16'h0102, 16'h0304);
    @(negedge clk);
    pulseRdy(16'h0506, 16'h0708);
    @(negedge clk);
    doFrame("status_ovr", 16'h9E00, 16);
    doFrame("ptch_h2", 16'hA300, 16);
    doFrame("status_clr", 16'h9E00, 16);

    // Reset in the middle of a PTCH_L read whose bit7 is 1
    pulseRdy(16'h00C3, 16'h0000);
    repeat (2) @(negedge clk);
    checkInt("pre_rst_int");
    sh = 16'hA200;
    SS_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      MOSI = sh[15];
      sh = {sh[14:0], 1'b0};
      repeat (5) @(negedge clk);
      SCLK = 1'b1;
      repeat (5) @(negedge clk);
      if (i < 8) SCLK = 1'b0;
    end
    checkOutput("pre_rst_miso", {15'b0, MISO}, 16'h0001);
    rst_n = 1'b0;
    SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("rst_mid_miso", {15'b0, MISO}, 16'h0000);
    checkOutput("rst_mid_int", {15'b0, INT}, 16'h0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    doFrame("whoami_after_rst", 16'h8F00, 16);

    doFrame("short_wr", 16'h0D02, 12);
    doFrame("ctrl_after_short", 16'h8D00, 16);
    doFrame("status_err", 16'h9E00, 16);
    doFrame("err_cnt", 16'hFF00, 16);
    doFrame("status_err_clr", 16'h9E00, 16);

    // Capture coincident with the clearing SS_n rise of a PTCH_H read
    doFrame("wr_ctrl2", 16'h0D02, 16);
    pulseRdy(16'h1111, 16'h2222);
    repeat (2) @(negedge clk);
    checkInt("coin_pre_int");
    ptch_data = 16'h5A5A; az_data = 16'hA5A5;
    exp = modelRead(7'h23);
    applyStimulus(16'hA300, 16, 1'b1, rb);
    checkOutput("coin_ptch_h", {8'h00, rb}, {8'h00, exp});
    prevNew = mNew;
    modelFrame(16'hA300, 16);
    mPtch = 16'h5A5A; mAz = 16'hA5A5;
    mNew = 1'b1; mOvr = prevNew;
    checkInt("coin_int");
    doFrame("coin_status", 16'h9E00, 16);

    // Randomized frames against the model
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: doFrame("rnd_read", {1'b1, addrs[$urandom_range(0, 8)], 8'h00}, 16);
        1: doFrame("rnd_write", {1'b0, ($urandom_range(0, 1) == 0) ? 7'h0D : addrs[$urandom_range(0, 8)],
                                 8'($urandom_range(0, 255))}, 16);
        2: begin
          pulseRdy(16'($urandom), 16'($urandom));
          repeat (2) @(negedge clk);
        end
        3: begin
          nb = ($urandom_range(0, 3) == 0) ? 17 : $urandom_range(1, 15);
          doFrame("rnd_short", 16'($urandom), nb);
        end
        default: doFrame("rnd_rd_key", ($urandom_range(0, 1) == 0) ? 16'hA300 : 16'h9E00, 16);
      endcase
      checkInt("rnd_int");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/inert_sensor_slv.md
Name: inert_sensor_slv

Overview:
- Cycle-accurate SPI responder that models the inertial sensor at the far end of the segway controller's SS_n/SCLK/MOSI/MISO/INT link.
- Holds a small register map and captures pitch and vertical-accel samples presented on its data ports.
- Raises INT when a new sample is ready and answers 16-bit read/write frames from the controller's SPI master.
- Used as the bench-side sensor for full-chip simulation and as an FPGA stand-in.

Parameters:
WHO_AM_I_VAL, 8'h6A, value returned from address 0x0F
SCLK_SYNC_STAGES, 2, flops in the SCLK/SS_n/MOSI synchronizers (min 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
SS_n  input  1  slave select from master, active low
SCLK  input  1  serial clock from master, idle low
MOSI  input  1  serial data from master
MISO  output  1  serial data to master
INT  output  1  data-ready interrupt, active high
ptch_data  input  16  signed pitch-rate sample source
az_data  input  16  signed vertical-accel sample source
data_rdy  input  1  one-clk pulse: capture ptch_data/az_data

Behaviour:
- Clocking: one clock (clk). rst_n is asynchronous and active-low. SS_n, SCLK and MOSI pass through SCLK_SYNC_STAGES-flop synchronizers. SCLK rise/fall pulses come from the synchronized SCLK. The SCLK period must be at least 8 clk periods.
- Frame format: SPI mode 0, MSB first, 16 bits.
  - Bit15 = R/W (1 = read).
  - Bits14:8 = address.
  - Bits7:0 = write data; don't-care on reads.
- Receive path:
  - MOSI is sampled on each detected SCLK rise into a 16-bit shift register.
  - A 5-bit bit counter clears on the synchronized SS_n fall.
- Read path:
  - On the 8th detected rise, the addressed register is loaded into an 8-bit tx register, and MISO = tx[7] from the next clk onward.
  - Each later detected fall shifts tx left, so the master samples data bits 7..0 on rises 9..16.
  - MISO = 0 while SS_n is high and during bits 15:8.
- Write path: commits only on the synchronized SS_n rise with bit count exactly 16. A frame with any other count is discarded.
- Register map (unmapped addresses read 0x00; writes to read-only or unmapped addresses are ignored):
  - 0x0D CTRL (R/W, reset 0x00): bit1 = INT_EN.
  - 0x0F WHO_AM_I (RO): WHO_AM_I_VAL.
  - 0x1E STATUS (RO): bit0 = new data, bit1 = overrun.
  - 0x22 / 0x23 PTCH_L / PTCH_H (RO).
  - 0x2C / 0x2D AZ_L / AZ_H (RO).
- Sample capture:
  - A data_rdy pulse latches ptch_data and az_data into the data registers and sets STATUS.bit0.
  - If STATUS.bit0 is already set, data_rdy also sets STATUS.bit1.
- Latching during an active frame: if data_rdy arrives while a read of a data register is past rise 8, the tx byte already loaded is unaffected; the new values are visible on the next frame.
- INT: registered. INT = STATUS.bit0 & INT_EN. It asserts the clk after capture.
- Clearing on read: a completed 16-bit read of PTCH_H clears STATUS.bit0 and STATUS.bit1 on the SS_n rise. INT falls on the next clk.
- Simultaneous data_rdy and a clearing SS_n rise in the same clk: the capture wins. Bit0 stays 1, and bit1 is set only if bit0 was 1 before that clk.
- Controller state machine: IDLE -> SHIFT on SS_n fall; SHIFT -> COMMIT on SS_n rise; COMMIT -> IDLE after one clk. Reset mid-frame returns to IDLE.
- Reset values: MISO=0, INT=0, all registers 0x00 except WHO_AM_I.

Optional Feature:
INERT_SLV_FRM_ERR_EN
- Defined:
  - Adds read-only register 0x7F ERR_CNT, an 8-bit saturating count of discarded frames (count != 16 at SS_n rise).
  - Adds STATUS.bit7, a sticky frame-error flag, cleared by reading ERR_CNT.
- Undefined: malformed frames are dropped silently, 0x7F reads 0x00, and STATUS.bit7 reads 0.

Decomposition:
- Package inert_slv_pkg:
  - Register address localparams (ADDR_CTRL, ADDR_WHO_AM_I, ADDR_STATUS, ADDR_PTCH_L/H, ADDR_AZ_L/H, ADDR_ERR_CNT).
  - CTRL/STATUS bit-index constants.
  - Typedef enum slv_state_t {IDLE, SHIFT, COMMIT}.
- Sub-module spi_slv_shft:
  - Synchronizers, SCLK edge detection, bit counter, rx shift register.
  - Outputs addr_vld (pulse at rise 8), frm_done (SS_n rise, count == 16), frm_err.
  - Takes rd_byte in and drives MISO.
- The top level holds the register map, capture, and INT logic.

Test Plan:
- Read 0x0F (frame 0x8F00) -> MISO byte 0x6A; INT stays 0.
- Write 0x0D=0x02, then data_rdy with ptch_data=16'hF3A5 -> INT=1 within 2 clk. Reading 0xA2 returns 0xA5, reading 0xA3 returns 0xF3, and INT=0 one clk after SS_n rise.
- Two data_rdy pulses with no read -> STATUS (0x9E) reads 0x03. After a PTCH_H read, STATUS reads 0x00.
- SS_n raised after 12 SCLKs on a write to 0x0D=0x02 -> CTRL stays 0x00. With INERT_SLV_FRM_ERR_EN, ERR_CNT=1.
- rst_n asserted mid-frame at bit 9 -> MISO=0, INT=0, FSM IDLE. The next full read of 0x0F returns 0x6A.
- data_rdy coincident with the SS_n rise ending a PTCH_H read -> INT remains 1, and STATUS.bit0=1.
